// File: rtl/muldiv_unit_if.sv
// Bundle of the issue and write-back signals of the RV32M multiply/divide unit.
// Latency: none, wires only.
// Backpressure: the unit raises busy while an operation is in flight; start is ignored then.
interface muldiv_unit_if;
  logic        start;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        flush;
  logic        busy;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  // Issuing side: the pipeline that drives requests and consumes write-back.
  modport master (
    output start, funct3, rd, rs1_val, rs2_val, flush,
    input  busy, wb_en, wb_rd, wb_data
  );

  // Execution side: the multiply/divide unit itself.
  modport slave (
    input  start, funct3, rd, rs1_val, rs2_val, flush,
    output busy, wb_en, wb_rd, wb_data
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide on magnitudes.
// Latency: fixed; wb_en pulses in the cycle after the 33rd edge following the accepting edge.
// Backpressure: busy is high from accept until the write-back edge; start is ignored meanwhile.
module muldiv_unit (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic        r_prep;   // first RUN cycle converts operands to magnitudes
  logic [2:0]  r_op;
  logic [4:0]  r_rd;
  logic [31:0] r_rs1;
  logic [31:0] r_rs2;
  logic [63:0] r_a;      // multiply: shifting multiplicand; divide: dividend/quotient in [31:0]
  logic [31:0] r_b;      // multiply: shifting multiplier; divide: divisor magnitude
  logic [63:0] r_acc;    // multiply: partial product; divide: partial remainder in [31:0]

  logic        w_is_div;
  logic        w_sgn_a;
  logic        w_sgn_b;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [63:0] w_acc_nx;
  logic [63:0] w_prod;
  logic [32:0] w_sh;
  logic [32:0] w_sub;
  logic        w_ge;
  logic [31:0] w_rem_nx;
  logic [31:0] w_quo_nx;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;
  logic        w_div0;
  logic [31:0] w_result;

  // Operand signedness per opcode and the resulting magnitudes.
  assign w_is_div = r_op[2];
  assign w_sgn_a  = w_is_div ? ~r_op[0] : (r_op[1:0] != 2'b11);
  assign w_sgn_b  = w_is_div ? ~r_op[0] : ~r_op[1];
  assign w_neg_a  = w_sgn_a & r_rs1[31];
  assign w_neg_b  = w_sgn_b & r_rs2[31];
  assign w_mag_a  = w_neg_a ? (~r_rs1 + 32'd1) : r_rs1;
  assign w_mag_b  = w_neg_b ? (~r_rs2 + 32'd1) : r_rs2;

  // One shift-add step; the corrected product is only consumed on the last step.
  assign w_acc_nx = r_acc + (r_b[0] ? r_a : 64'd0);
  assign w_prod   = (w_neg_a ^ w_neg_b) ? (~w_acc_nx + 64'd1) : w_acc_nx;

  // One restoring-divide step: bring in the next dividend bit, keep the difference if no borrow.
  assign w_sh      = {r_acc[31:0], r_a[31]};
  assign w_sub     = w_sh - {1'b0, r_b};
  assign w_ge      = ~w_sub[32];
  assign w_rem_nx  = w_ge ? w_sub[31:0] : w_sh[31:0];
  assign w_quo_nx  = {r_a[30:0], w_ge};
  assign w_quo_fix = (w_neg_a ^ w_neg_b) ? (~w_quo_nx + 32'd1) : w_quo_nx;
  assign w_rem_fix = w_neg_a ? (~w_rem_nx + 32'd1) : w_rem_nx;
  assign w_div0    = (r_rs2 == 32'd0);

  // Final result select; divide-by-zero overrides the iterated values.
  always_comb begin
    w_result = w_prod[31:0];
    case (r_op)
      3'b000:                 w_result = w_prod[31:0];
      3'b001, 3'b010, 3'b011: w_result = w_prod[63:32];
      3'b100:                 w_result = w_div0 ? 32'hFFFF_FFFF : w_quo_fix;
      3'b101:                 w_result = w_div0 ? 32'hFFFF_FFFF : w_quo_nx;
      3'b110:                 w_result = w_div0 ? r_rs1 : w_rem_fix;
      default:                w_result = w_div0 ? r_rs1 : w_rem_nx;
    endcase
  end

  // Control FSM, iteration datapath and registered write-back outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 5'd0;
      r_prep      <= 1'b0;
      r_op        <= 3'd0;
      r_rd        <= 5'd0;
      r_rs1       <= 32'd0;
      r_rs2       <= 32'd0;
      r_a         <= 64'd0;
      r_b         <= 32'd0;
      r_acc       <= 64'd0;
      bus.busy    <= 1'b0;
      bus.wb_en   <= 1'b0;
      bus.wb_rd   <= 5'd0;
      bus.wb_data <= 32'd0;
    end else begin
      bus.wb_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start && !bus.flush) begin
            r_op     <= bus.funct3;
            r_rd     <= bus.rd;
            r_rs1    <= bus.rs1_val;
            r_rs2    <= bus.rs2_val;
            r_cnt    <= 5'd0;
            r_prep   <= 1'b1;
            r_state  <= S_RUN;
            bus.busy <= 1'b1;
          end
        end
        S_RUN: begin
          if (bus.flush) begin
            r_state  <= S_IDLE;
            bus.busy <= 1'b0;
          end else if (r_prep) begin
            r_prep <= 1'b0;
            r_a    <= {32'd0, w_mag_a};
            r_b    <= w_mag_b;
            r_acc  <= 64'd0;
          end else begin
            r_cnt <= r_cnt + 5'd1;
            if (w_is_div) begin
              r_acc <= {32'd0, w_rem_nx};
              r_a   <= {32'd0, w_quo_nx};
            end else begin
              r_acc <= w_acc_nx;
              r_a   <= {r_a[62:0], 1'b0};
              r_b   <= {1'b0, r_b[31:1]};
            end
            if (r_cnt == 5'd31) begin
              r_state     <= S_DONE;
              bus.wb_en   <= (r_rd != 5'd0);
              bus.wb_rd   <= r_rd;
              bus.wb_data <= w_result;
            end
          end
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized operations.
// Results come from a plain-arithmetic model; timing checks count cycles around each accept.
// Also covers start held during RUN, flush, flush-vs-start priority and asynchronous reset.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  muldiv_unit_if bus ();

  muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference results from integer arithmetic on the architectural operand values.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic scramble();
    bus.funct3  = 3'($urandom);
    bus.rd      = 5'($urandom);
    bus.rs1_val = $urandom;
    bus.rs2_val = $urandom;
  endtask

  task automatic watch_no_wb(input string tag, input int n);
    int cnt;
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (bus.wb_en) cnt++;
    end
    chk(tag, 64'(cnt), 64'd0);
  endtask

  // Issue one op at a negedge and check timing and results; returns at the negedge
  // after busy falls so the next call issues back-to-back.
  task automatic issue(input logic [2:0] op, input logic [4:0] dst, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit hold);
    int          wb_cnt;
    int          wb_at;
    int          busy_cnt;
    logic [4:0]  got_rd;
    logic [31:0] got_dat;
    chk("idle_before_issue", 64'(bus.busy), 64'd0);
    bus.start   = 1'b1;
    bus.funct3  = op;
    bus.rd      = dst;
    bus.rs1_val = a;
    bus.rs2_val = b;
    @(posedge clk);
    @(negedge clk);
    scramble();
    bus.start = hold;
    busy_cnt  = bus.busy ? 1 : 0;
    wb_cnt    = bus.wb_en ? 1 : 0;
    wb_at     = -1;
    got_rd    = 5'd0;
    got_dat   = 32'd0;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (hold && k == 32) bus.start = 1'b0;
      if (bus.busy) busy_cnt++;
      if (bus.wb_en) begin
        wb_cnt++;
        wb_at = k;
      end
      if (k == 33) begin
        got_rd  = bus.wb_rd;
        got_dat = bus.wb_data;
      end
    end
    bus.start = 1'b0;
    chk("wb_en_count", 64'(wb_cnt), (dst != 5'd0) ? 64'd1 : 64'd0);
    if (dst != 5'd0) chk("wb_en_cycle", 64'(wb_at), 64'd33);
    chk("busy_cycles", 64'(busy_cnt), 64'd34);
    chk("busy_after_done", 64'(bus.busy), 64'd0);
    chk("wb_rd", 64'(got_rd), 64'(dst));
    chk("wb_data", 64'(got_dat), 64'(exp));
    chk("wb_data_hold", 64'(bus.wb_data), 64'(exp));
  endtask

  initial begin
    logic [2:0]  op;
    logic [4:0]  dst;
    logic [31:0] a;
    logic [31:0] b;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.flush   = 1'b0;
    bus.funct3  = 3'd0;
    bus.rd      = 5'd0;
    bus.rs1_val = 32'd0;
    bus.rs2_val = 32'd0;
    #1;
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_wb_en", 64'(bus.wb_en), 64'd0);
    chk("reset_wb_rd", 64'(bus.wb_rd), 64'd0);
    chk("reset_wb_data", 64'(bus.wb_data), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed corner cases with hand-computed results.
    issue(3'd0, 5'd5,  32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    issue(3'd3, 5'd1,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    issue(3'd1, 5'd2,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    issue(3'd2, 5'd3,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(3'd4, 5'd4,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    issue(3'd6, 5'd6,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    issue(3'd5, 5'd7,  32'd20,        32'd0,         32'hFFFF_FFFF, 1'b0);
    issue(3'd7, 5'd8,  32'd20,        32'd0,         32'd20,        1'b0);
    issue(3'd4, 5'd9,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0);
    issue(3'd6, 5'd10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0);
    issue(3'd4, 5'd11, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1'b0);
    issue(3'd6, 5'd12, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1'b0);
    issue(3'd0, 5'd0,  32'd3,         32'd4,         32'd12,        1'b0);

    // Flush in the middle of RUN.
    bus.start = 1'b1; bus.funct3 = 3'd4; bus.rd = 5'd3;
    bus.rs1_val = 32'd100; bus.rs2_val = 32'd7;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    watch_no_wb("flush_no_wb", 40);
    issue(3'd5, 5'd13, 32'd100, 32'd7, 32'd14, 1'b0);

    // Flush wins over start in the same cycle.
    bus.start = 1'b1; bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_prio_busy", 64'(bus.busy), 64'd0);
    bus.start = 1'b0; bus.flush = 1'b0;
    watch_no_wb("flush_prio_no_wb", 40);

    // Asynchronous reset mid-operation, between clock edges.
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.rd = 5'd9;
    bus.rs1_val = 32'd5; bus.rs2_val = 32'd6;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 15; k++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_wb_en", 64'(bus.wb_en), 64'd0);
    chk("rst_wb_rd", 64'(bus.wb_rd), 64'd0);
    chk("rst_wb_data", 64'(bus.wb_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    watch_no_wb("rst_no_wb", 40);
    issue(3'd7, 5'd14, 32'd23, 32'd5, 32'd3, 1'b0);

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 25; i++) begin
      op  = 3'($urandom);
      a   = pick_operand();
      b   = pick_operand();
      dst = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      issue(op, dst, a, b, model(op, a, b), ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
Parameters: none; datapath width fixed at 32 bits.
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port clk, input, 1: rising-edge clock for all state.
REQ-003 Port rst, input, 1: asynchronous active-high reset.
REQ-004 Port start, input, 1: request to begin an operation.
REQ-005 Port funct3, input, 3: RV32M op (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-006 Port rd, input, 5: destination register index.
REQ-007 Port rs1_val, input, 32: operand A, taken from register-file read port 1.
REQ-008 Port rs2_val, input, 32: operand B, taken from register-file read port 2.
REQ-009 Port flush, input, 1: abort any operation in flight.
REQ-010 Port busy, output, 1: operation in flight; new start is not accepted.
REQ-011 Port wb_en, output, 1: one-cycle register-file write enable.
REQ-012 Port wb_rd, output, 5: register-file write address.
REQ-013 Port wb_data, output, 32: register-file write data.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN, DONE; busy=1 in RUN and DONE.
REQ-015 In IDLE, start=1 and flush=0 at an edge SHALL latch funct3, rd, rs1_val and rs2_val, clear a 5-bit counter and enter RUN.
REQ-016 start in RUN or DONE SHALL be ignored; operands are not re-sampled.
REQ-017 RUN SHALL process one operand bit per cycle (shift-add multiply, restoring divide) on operand magnitudes, for exactly 32 cycles, then enter DONE.
REQ-018 Signedness: MUL/MULH/DIV/REM treat both operands as signed; MULHSU treats rs1 signed and rs2 unsigned; MULHU/DIVU/REMU treat both as unsigned.
REQ-019 Result sign correction SHALL be applied in the final RUN cycle.
REQ-020 MUL SHALL return product bits [31:0]; MULH/MULHSU/MULHU SHALL return product bits [63:32].
REQ-021 Divide by zero: DIV/DIVU SHALL return 0xFFFFFFFF; REM/REMU SHALL return rs1.
REQ-022 Signed overflow (0x80000000 / 0xFFFFFFFF): DIV SHALL return 0x80000000; REM SHALL return 0.
REQ-023 Signed remainder SHALL take the sign of the dividend; the quotient SHALL truncate toward zero.
REQ-024 Latency SHALL be fixed, including the special cases: wb_en is high in the cycle after the 33rd edge following the accepting edge, for exactly one cycle.
REQ-025 DONE SHALL last one cycle and then return to IDLE; busy falls on the same edge as wb_en.
REQ-026 With latched rd=0, wb_en SHALL stay 0 while timing and busy are unchanged.
REQ-027 wb_rd and wb_data SHALL update when DONE is entered and hold until the next DONE.
REQ-028 flush=1 at an edge SHALL return the FSM to IDLE with no wb_en.
REQ-029 flush SHALL take priority over start in the same cycle.
REQ-030 A start in the cycle after DONE SHALL be accepted (back-to-back issue).

Reset
REQ-031 While rst=1, the FSM SHALL be IDLE and busy, wb_en, wb_rd and wb_data SHALL be 0, with no clock edge required.
REQ-032 Assertion of rst mid-operation SHALL discard the operation with no later wb_en.
REQ-033 After deassertion of rst, the first start at a clock edge SHALL be accepted normally.

Verification
REQ-034 MUL rs1=7, rs2=0xFFFFFFFD, rd=5 -> wb_en pulses 33 cycles after accept, wb_rd=5, wb_data=0xFFFFFFEB.
REQ-035 rs1=rs2=0xFFFFFFFF -> MULHU 0xFFFFFFFE; MULH 0x00000000; MULHSU 0xFFFFFFFF.
REQ-036 DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM 0; DIVU 20/0 -> 0xFFFFFFFF, REMU 20/0 -> 20; DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF.
REQ-037 start held high through RUN -> a single wb_en; flush at cycle 10 -> no wb_en, busy=0 next cycle, following start accepted.
REQ-038 rst asserted at cycle 15 between clock edges -> outputs 0 immediately and no wb_en afterwards; rd=0 op -> busy for 34 cycles, wb_en never 1.
